// File: rtl/lpc_io_decoder.sv
// LPC I/O slave front end.
// Follows host I/O read/write cycles on LFRAME#/LAD and claims the ones that
// land in a 2^WIN_BITS byte window at BASE_ADDR. Hits drive the register-file
// strobes Addr/Wr/DataWr, and read data comes back on LAD. Misses, other cycle
// types and aborted cycles are ignored, and LAD is never driven for them.
module lpc_io_decoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int          WIN_BITS  = 5
) (
    input  logic       PciReset,
    input  logic       LpcClock,
    input  logic       LFrame_n,
    input  logic [3:0] LadIn,
    output logic [3:0] LadOut,
    output logic       LadOe,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWr
);

    // LAD codes used by the host during START and CYCTYPE
    localparam logic [3:0] LAD_START    = 4'h0;
    localparam logic [3:0] CYC_IO_READ  = 4'h0;
    localparam logic [3:0] CYC_IO_WRITE = 4'h2;
    localparam logic [3:0] LAD_SYNC_OK  = 4'h0;
    localparam logic [3:0] LAD_IDLE     = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        CYCTYPE,
        ADDR0,
        ADDR1,
        ADDR2,
        ADDR3,
        WDATA0,
        WDATA1,
        HTAR0,
        HTAR1,
        SYNC,
        RDATA0,
        RDATA1,
        PTAR0,
        PTAR1
    } state_t;

    state_t      state;
    state_t      next_state;

    // The top three address nibbles are collected here. The last nibble is
    // used straight from LAD so the window compare finishes at the end of ADDR3.
    logic [11:0] addr_shift;
    logic [15:0] addr_full;
    logic        addr_hit;

    logic        is_write;
    logic [3:0]  wdata_low;
    logic [7:0]  rd_shift;

    assign addr_full = {addr_shift, LadIn};
    assign addr_hit  = (addr_full[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);

    // State register
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. LFRAME# low always wins: a START nibble restarts
    // decoding, and any other nibble (abort included) returns to IDLE.
    always_comb begin
        next_state = state;
        if (!LFrame_n) begin
            next_state = (LadIn == LAD_START) ? CYCTYPE : IDLE;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                CYCTYPE: begin
                    if (LadIn == CYC_IO_READ || LadIn == CYC_IO_WRITE) begin
                        next_state = ADDR0;
                    end else begin
                        next_state = IDLE;
                    end
                end
                ADDR0:   next_state = ADDR1;
                ADDR1:   next_state = ADDR2;
                ADDR2:   next_state = ADDR3;
                ADDR3: begin
                    if (!addr_hit) begin
                        next_state = IDLE;
                    end else if (is_write) begin
                        next_state = WDATA0;
                    end else begin
                        next_state = HTAR0;
                    end
                end
                WDATA0:  next_state = WDATA1;
                WDATA1:  next_state = HTAR0;
                HTAR0:   next_state = HTAR1;
                HTAR1:   next_state = SYNC;
                SYNC:    next_state = is_write ? PTAR0 : RDATA0;
                RDATA0:  next_state = RDATA1;
                RDATA1:  next_state = PTAR0;
                PTAR0:   next_state = PTAR1;
                PTAR1:   next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Cycle direction and address capture. Nothing is captured on a clock
    // where LFRAME# is low, because that clock belongs to the next cycle.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            is_write   <= 1'b0;
            addr_shift <= '0;
            Addr       <= '0;
        end else if (LFrame_n) begin
            case (state)
                CYCTYPE: is_write <= (LadIn == CYC_IO_WRITE);
                ADDR0, ADDR1, ADDR2: addr_shift <= {addr_shift[7:0], LadIn};
                ADDR3: begin
                    if (addr_hit) begin
                        Addr <= 8'(addr_full[WIN_BITS-1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write data assembly (low nibble first) and read data capture at SYNC.
    // The read capture relies on Addr having been stable since ADDR3.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            wdata_low <= '0;
            DataWr    <= '0;
            rd_shift  <= '0;
        end else if (LFrame_n) begin
            case (state)
                WDATA0:  wdata_low <= LadIn;
                WDATA1:  DataWr    <= {LadIn, wdata_low};
                SYNC: begin
                    if (!is_write) begin
                        rd_shift <= RdData;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode: LAD ownership, SYNC/read nibbles and the write strobe
    always_comb begin
        LadOe  = 1'b0;
        LadOut = LAD_IDLE;
        Wr     = 1'b0;
        case (state)
            SYNC: begin
                LadOe  = 1'b1;
                LadOut = LAD_SYNC_OK;
                Wr     = is_write;
            end
            RDATA0: begin
                LadOe  = 1'b1;
                LadOut = rd_shift[3:0];
            end
            RDATA1: begin
                LadOe  = 1'b1;
                LadOut = rd_shift[7:4];
            end
            PTAR0: begin
                LadOe  = 1'b1;
                LadOut = LAD_IDLE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lpc_io_decoder.sv
// Testbench for lpc_io_decoder.
// Host cycles are built as per-clock LAD/LFRAME# slot sequences, and the
// expected bus response is looked up from a per-transaction table of what the
// slave owes the host. A small register-file array supplies RdData.
module tb_lpc_io_decoder;

    localparam logic [15:0] BASE = 16'h0800;

    logic       PciReset;
    logic       LpcClock;
    logic       LFrame_n;
    logic [3:0] LadIn;
    logic [3:0] LadOut;
    logic       LadOe;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWr;

    logic [7:0] reg_file  [32];
    logic [7:0] model_mem [32];
    logic       preload;

    logic [7:0] exp_addr;
    logic [7:0] exp_data;

    int vectors;
    int miscompares;

    lpc_io_decoder #(.BASE_ADDR(16'h0800), .WIN_BITS(5)) dut (
        .PciReset (PciReset),
        .LpcClock (LpcClock),
        .LFrame_n (LFrame_n),
        .LadIn    (LadIn),
        .LadOut   (LadOut),
        .LadOe    (LadOe),
        .RdData   (RdData),
        .Addr     (Addr),
        .Wr       (Wr),
        .DataWr   (DataWr)
    );

    // 33 MHz LPC clock
    initial begin
        LpcClock = 1'b0;
        forever #15 LpcClock = ~LpcClock;
    end

    // Register file seen by the DUT; it is loaded from the model once, then
    // only the DUT's own write strobes change it
    always @(posedge LpcClock) begin
        if (preload) begin
            reg_file <= model_mem;
        end else if (Wr) begin
            reg_file[Addr[4:0]] <= DataWr;
        end
    end

    assign RdData = reg_file[Addr[4:0]];

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one LPC clock slot, then settle just after the edge
    task automatic applyStimulus(input logic frame_n, input logic [3:0] lad);
        @(negedge LpcClock);
        LFrame_n = frame_n;
        LadIn    = lad;
        @(posedge LpcClock);
        #1;
    endtask

    task automatic checkSlot(input logic e_oe, input logic [3:0] e_out, input logic e_wr);
        checkOutput("LadOe", {7'b0, LadOe}, {7'b0, e_oe});
        if (e_oe) begin
            checkOutput("LadOut", {4'b0, LadOut}, {4'b0, e_out});
        end
        checkOutput("Wr", {7'b0, Wr}, {7'b0, e_wr});
        checkOutput("Addr", Addr, exp_addr);
        checkOutput("DataWr", DataWr, exp_data);
    endtask

    task automatic idleSlots(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 4'($urandom));
            checkSlot(1'b0, 4'hF, 1'b0);
        end
    endtask

    // kind: 0 I/O read, 1 I/O write, 2 other cycle type (code), 3 bad START (code)
    // abort_slot: slot carrying LFRAME#=0/LAD=F, or -1 for none
    task automatic runTransaction(input int kind, input logic [15:0] io_addr,
                                  input logic [7:0] wdata, input logic [3:0] code,
                                  input int abort_slot, input bit extra_start,
                                  input int num_slots);
        logic       is_io;
        logic       wr_cycle;
        logic       hit;
        logic [7:0] rexp;
        is_io    = (kind == 0) || (kind == 1);
        wr_cycle = (kind == 1);
        hit      = is_io && ((io_addr & 16'hFFE0) == BASE);
        rexp     = model_mem[io_addr[4:0]];
        if (extra_start) begin
            applyStimulus(1'b0, 4'h0);
            checkSlot(1'b0, 4'hF, 1'b0);
        end
        for (int i = 0; i < num_slots; i++) begin
            logic       f;
            logic [3:0] l;
            logic       e_oe;
            logic [3:0] e_out;
            logic       e_wr;
            f = 1'b1;
            l = 4'($urandom);
            if (i == 0) begin
                f = 1'b0;
                l = (kind == 3) ? code : 4'h0;
            end else if (i == 1 && kind != 3) begin
                l = (kind == 0) ? 4'h0 : (kind == 1) ? 4'h2 : code;
            end else if (i >= 2 && i <= 5 && is_io) begin
                l = io_addr[4*(5-i) +: 4];
            end else if (i == 6 && wr_cycle) begin
                l = wdata[3:0];
            end else if (i == 7 && wr_cycle) begin
                l = wdata[7:4];
            end
            if (i == abort_slot) begin
                f = 1'b0;
                l = 4'hF;
            end
            applyStimulus(f, l);

            e_oe  = 1'b0;
            e_out = 4'hF;
            e_wr  = 1'b0;
            if (abort_slot < 0 || i < abort_slot) begin
                if (hit && wr_cycle) begin
                    if (i == 9) begin
                        e_oe = 1'b1; e_out = 4'h0; e_wr = 1'b1;
                    end else if (i == 10) begin
                        e_oe = 1'b1; e_out = 4'hF;
                    end
                end else if (hit) begin
                    if (i == 7) begin
                        e_oe = 1'b1; e_out = 4'h0;
                    end else if (i == 8) begin
                        e_oe = 1'b1; e_out = rexp[3:0];
                    end else if (i == 9) begin
                        e_oe = 1'b1; e_out = rexp[7:4];
                    end else if (i == 10) begin
                        e_oe = 1'b1; e_out = 4'hF;
                    end
                end
                if (hit && i == 5) exp_addr = {3'b000, io_addr[4:0]};
                if (hit && wr_cycle && i == 7) exp_data = wdata;
                if (hit && wr_cycle && i == 9) model_mem[io_addr[4:0]] = wdata;
            end
            checkSlot(e_oe, e_out, e_wr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        PciReset    = 1'b0;
        LFrame_n    = 1'b1;
        LadIn       = 4'hF;
        preload     = 1'b1;
        exp_addr    = 8'h00;
        exp_data    = 8'h00;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'($urandom);
        model_mem[31] = 8'h5A;

        // Reset values, before any clock edge
        #5;
        checkOutput("rst_LadOe", {7'b0, LadOe}, 8'h00);
        checkOutput("rst_LadOut", {4'b0, LadOut}, 8'h0F);
        checkOutput("rst_Addr", Addr, 8'h00);
        checkOutput("rst_Wr", {7'b0, Wr}, 8'h00);
        checkOutput("rst_DataWr", DataWr, 8'h00);

        @(posedge LpcClock);
        @(negedge LpcClock);
        preload  = 1'b0;
        PciReset = 1'b1;
        idleSlots(2);

        $display("[TB] directed cycles");
        runTransaction(1, 16'h0801, 8'h3C, 4'h0, -1, 1'b0, 13);
        idleSlots(1);
        runTransaction(0, 16'h081F, 8'h00, 4'h0, -1, 1'b0, 13);
        idleSlots(1);
        runTransaction(1, 16'h0900, 8'hA7, 4'h0, -1, 1'b0, 13);
        runTransaction(0, 16'h0820, 8'h00, 4'h0, -1, 1'b0, 13);
        idleSlots(1);
        runTransaction(1, 16'h0804, 8'h96, 4'h0, 7, 1'b0, 13);
        runTransaction(1, 16'h0805, 8'hE1, 4'h0, -1, 1'b0, 13);
        runTransaction(0, 16'h0805, 8'h00, 4'h0, -1, 1'b0, 13);
        runTransaction(2, 16'h0803, 8'h00, 4'h4, -1, 1'b0, 13);
        runTransaction(3, 16'h0803, 8'h00, 4'h2, -1, 1'b0, 13);
        runTransaction(1, 16'h0806, 8'h42, 4'h0, -1, 1'b1, 13);
        runTransaction(0, 16'h0806, 8'h00, 4'h0, 9, 1'b0, 13);
        idleSlots(2);

        $display("[TB] reset during RDATA0");
        runTransaction(0, 16'h081F, 8'h00, 4'h0, -1, 1'b0, 9);
        #5;
        PciReset = 1'b0;
        #2;
        exp_addr = 8'h00;
        exp_data = 8'h00;
        checkOutput("mid_rst_LadOe", {7'b0, LadOe}, 8'h00);
        checkOutput("mid_rst_LadOut", {4'b0, LadOut}, 8'h0F);
        checkOutput("mid_rst_Addr", Addr, 8'h00);
        checkOutput("mid_rst_Wr", {7'b0, Wr}, 8'h00);
        checkOutput("mid_rst_DataWr", DataWr, 8'h00);
        @(negedge LpcClock);
        PciReset = 1'b1;
        idleSlots(2);

        $display("[TB] random cycles");
        for (int t = 0; t < 80; t++) begin
            int         sel;
            int         kind;
            int         abort_slot;
            logic [15:0] a;
            logic [3:0] code;
            bit         xs;
            sel  = $urandom_range(0, 9);
            kind = (sel <= 3) ? 0 : (sel <= 7) ? 1 : (sel == 8) ? 2 : 3;
            if ($urandom_range(0, 9) < 6) begin
                a = BASE | 16'($urandom_range(0, 31));
            end else begin
                a = 16'($urandom);
                if ((a & 16'hFFE0) == BASE) a[12] = ~a[12];
            end
            code = 4'($urandom_range(1, 15));
            if (kind == 2 && code == 4'h2) code = 4'h4;
            abort_slot = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1;
            xs = ($urandom_range(0, 6) == 0);
            runTransaction(kind, a, 8'($urandom), code, abort_slot, xs, 13);
            idleSlots($urandom_range(0, 2));
        end
        idleSlots(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
